// File: rtl/isa_pi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | isa_pi_pkg : status-bit layout, read-port offsets and read constants |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package isa_pi_pkg;

    localparam int STAT_OUT_EMPTY = 0;
    localparam int STAT_IN_AVAIL  = 1;
    localparam int STAT_OUT_OVF   = 2;
    localparam int STAT_IN_OVF    = 3;

    localparam logic [7:0] EMPTY_READ = 8'hFF;

    // Read ports sit directly above the write-channel window.
    function automatic logic [9:0] status_ofs(input int nch);
        return 10'(nch);
    endfunction

    function automatic logic [9:0] data_ofs(input int nch);
        return 10'(nch + 1);
    endfunction

    function automatic logic [7:0] status_byte(input logic in_ovf, input logic out_ovf,
                                               input logic in_avail, input logic out_empty);
        logic [7:0] s;
        s                 = '0;
        s[STAT_IN_OVF]    = in_ovf;
        s[STAT_OUT_OVF]   = out_ovf;
        s[STAT_IN_AVAIL]  = in_avail;
        s[STAT_OUT_EMPTY] = out_empty;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/isa_pi_link_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : power-of-two FIFO moving up to two entries per side/cycle|
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int AW        = 4,
    parameter bit DUAL_PUSH = 1'b1,
    parameter bit DUAL_POP  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [1:0]       push_n,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [1:0]       pop_n,
    output logic [WIDTH-1:0] dout0,
    output logic [WIDTH-1:0] dout1,
    output logic [AW:0]      count,
    output logic             rd_lsb
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic [1:0]       w_push_req;
    logic [1:0]       w_pop_req;
    logic [1:0]       w_push;
    logic [1:0]       w_pop;
    logic [AW:0]      w_free;

    generate
        if (DUAL_PUSH) begin : g_dual_push
            assign w_push_req = push_n;
        end else begin : g_single_push
            assign w_push_req = {1'b0, |push_n};
        end
        if (DUAL_POP) begin : g_dual_pop
            assign w_pop_req = pop_n;
        end else begin : g_single_pop
            assign w_pop_req = {1'b0, |pop_n};
        end
    endgenerate

    // A request that does not fit entirely is refused whole, so pairs never split.
    assign w_free = (AW+1)'(DEPTH) - r_cnt;
    assign w_push = ((AW+1)'(w_push_req) <= w_free) ? w_push_req : 2'd0;
    assign w_pop  = ((AW+1)'(w_pop_req) <= r_cnt) ? w_pop_req : 2'd0;

    always_ff @(posedge clk) begin
        if (!flush && w_push != 2'd0) begin
            r_mem[r_wr] <= din0;
        end
        if (!flush && w_push == 2'd2) begin
            r_mem[r_wr + AW'(1)] <= din1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= r_wr + AW'(w_push);
            r_rd  <= r_rd + AW'(w_pop);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    assign dout0  = r_mem[r_rd];
    assign dout1  = r_mem[r_rd + AW'(1)];
    assign count  = r_cnt;
    assign rd_lsb = r_rd[0];

endmodule
`default_nettype wire

// File: rtl/isa_pi_link.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | isa_pi_link : ISA I/O window bridged to a Raspberry Pi GPIO handshake|
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module isa_pi_link
    import isa_pi_pkg::*;
#(
    parameter logic [9:0] PORT_BASE = 10'h170,
    parameter int         NCH       = 4,
    parameter int         OUT_AW    = 8,
    parameter int         IN_AW     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] A,
    input  logic [7:0] D_i,
    output logic [7:0] D_o,
    output logic       D_oe,
    input  logic       IOR,
    input  logic       IOW,
    output logic [7:0] GPIO_AD,
    output logic [1:0] REQ,
    input  logic       ACK,
    input  logic [3:0] GPIO_DI,
    input  logic       GPIO_ICL,
    output logic       ovf
);

    localparam int OUT_DEPTH = 1 << OUT_AW;
    localparam int IN_DEPTH  = 1 << IN_AW;

    // [0],[1] synchronise; [2] holds the previous synchronised value.
    logic [2:0] r_iow_s, r_ior_s, r_ack_s, r_icl_s;
    logic [1:0] r_warm;
    logic       r_out_ovf, r_in_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_iow_s <= '0;
            r_ior_s <= '0;
            r_ack_s <= '0;
            r_icl_s <= '0;
            r_warm  <= '0;
        end else begin
            r_iow_s <= {r_iow_s[1:0], IOW};
            r_ior_s <= {r_ior_s[1:0], IOR};
            r_ack_s <= {r_ack_s[1:0], ACK};
            r_icl_s <= {r_icl_s[1:0], GPIO_ICL};
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end
        end
    end

    // Idle-high strobes would look like rising edges while the chain fills after reset.
    logic w_live;
    logic w_iow_rise, w_ior_fall, w_ior_rise, w_ack_rise, w_icl_rise;

    assign w_live     = (r_warm == 2'd3);
    assign w_iow_rise = w_live &  r_iow_s[1] & ~r_iow_s[2];
    assign w_ior_fall = w_live & ~r_ior_s[1] &  r_ior_s[2];
    assign w_ior_rise = w_live &  r_ior_s[1] & ~r_ior_s[2];
    assign w_ack_rise = w_live &  r_ack_s[1] & ~r_ack_s[2];
    assign w_icl_rise = w_live &  r_icl_s[1] & ~r_icl_s[2];

    logic [9:0] w_ofs;
    logic       w_hit_ch, w_hit_stat, w_hit_data;

    assign w_ofs      = A - PORT_BASE;
    assign w_hit_ch   = (w_ofs < 10'(NCH));
    assign w_hit_stat = (w_ofs == status_ofs(NCH));
    assign w_hit_data = (w_ofs == data_ofs(NCH));

    logic [OUT_AW:0] w_out_cnt;
    logic [7:0]      w_out_head, w_out_d1;
    logic            w_out_rd_lsb;
    logic            w_out_room, w_out_drop;
    logic [1:0]      w_out_push, w_out_pop;

    assign w_out_room = (w_out_cnt <= (OUT_AW+1)'(OUT_DEPTH - 2));
    assign w_out_drop = w_iow_rise & w_hit_ch & ~w_out_room;
    assign w_out_push = (w_iow_rise && w_hit_ch && w_out_room) ? 2'd2 : 2'd0;
    assign w_out_pop  = (w_ack_rise && w_out_cnt != '0) ? 2'd1 : 2'd0;

    sync_fifo #(
        .WIDTH     (8),
        .AW        (OUT_AW),
        .DUAL_PUSH (1'b1),
        .DUAL_POP  (1'b0)
    ) u_out_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (1'b0),
        .push_n (w_out_push),
        .din0   ({4'h0, w_ofs[3:0]}),
        .din1   (D_i),
        .pop_n  (w_out_pop),
        .dout0  (w_out_head),
        .dout1  (w_out_d1),
        .count  (w_out_cnt),
        .rd_lsb (w_out_rd_lsb)
    );

    logic [IN_AW:0] w_in_cnt;
    logic [3:0]     w_in_d0, w_in_d1;
    logic           w_in_rd_lsb;
    logic           w_in_full, w_in_drop, w_in_avail;
    logic           w_stat_wr, w_flush, w_clr, w_rd_stat, w_rd_data;
    logic [1:0]     w_in_push, w_in_pop;

    assign w_in_full  = (w_in_cnt == (IN_AW+1)'(IN_DEPTH));
    assign w_in_avail = (w_in_cnt >= (IN_AW+1)'(2));
    assign w_in_drop  = w_icl_rise & w_in_full;
    assign w_in_push  = (w_icl_rise && !w_in_full) ? 2'd1 : 2'd0;
    assign w_stat_wr  = w_iow_rise & w_hit_stat;
    assign w_flush    = w_stat_wr & D_i[0];
    assign w_clr      = w_stat_wr & D_i[1];
    assign w_rd_stat  = w_ior_fall & w_hit_stat;
    assign w_rd_data  = w_ior_fall & w_hit_data;
    assign w_in_pop   = (w_rd_data && w_in_avail) ? 2'd2 : 2'd0;

    sync_fifo #(
        .WIDTH     (4),
        .AW        (IN_AW),
        .DUAL_PUSH (1'b0),
        .DUAL_POP  (1'b1)
    ) u_in_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (w_flush),
        .push_n (w_in_push),
        .din0   (GPIO_DI),
        .din1   (4'h0),
        .pop_n  (w_in_pop),
        .dout0  (w_in_d0),
        .dout1  (w_in_d1),
        .count  (w_in_cnt),
        .rd_lsb (w_in_rd_lsb)
    );

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, w_out_d1, w_in_rd_lsb};

    // A drop in the same cycle as a clear still leaves the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_ovf <= 1'b0;
            r_in_ovf  <= 1'b0;
        end else begin
            if (w_clr) begin
                r_out_ovf <= 1'b0;
                r_in_ovf  <= 1'b0;
            end
            if (w_out_drop) begin
                r_out_ovf <= 1'b1;
            end
            if (w_in_drop) begin
                r_in_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            D_o  <= '0;
            D_oe <= 1'b0;
        end else if (w_rd_stat) begin
            D_o  <= status_byte(r_in_ovf, r_out_ovf, w_in_avail, (w_out_cnt == '0));
            D_oe <= 1'b1;
        end else if (w_rd_data) begin
            D_o  <= w_in_avail ? {w_in_d1, w_in_d0} : EMPTY_READ;
            D_oe <= 1'b1;
        end else if (w_ior_rise) begin
            D_oe <= 1'b0;
        end
    end

    // Tags are always written at even addresses, so pointer bit 0 gives the phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            REQ     <= 2'b00;
            GPIO_AD <= '0;
        end else if (w_out_cnt != '0) begin
            REQ     <= {w_out_rd_lsb, 1'b1};
            GPIO_AD <= w_out_head;
        end else begin
            REQ     <= 2'b00;
        end
    end

    assign ovf = r_out_ovf | r_in_ovf;

endmodule
`default_nettype wire

// File: tb/tb_isa_pi_link.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_isa_pi_link : randomized and directed bench with a queue model    |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_isa_pi_link;

    localparam logic [9:0] BASE      = 10'h170;
    localparam int         NCH       = 4;
    localparam int         OUT_AW    = 3;
    localparam int         IN_AW     = 3;
    localparam int         OUT_DEPTH = 8;
    localparam int         IN_DEPTH  = 8;
    localparam logic [9:0] STAT_PORT = 10'h174;
    localparam logic [9:0] DATA_PORT = 10'h175;
    localparam logic [9:0] IDLE_A    = 10'h000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] A = IDLE_A;
    logic [7:0] D_i = 8'h00;
    logic [7:0] D_o;
    logic       D_oe;
    logic       IOR = 1'b1;
    logic       IOW = 1'b1;
    logic [7:0] GPIO_AD;
    logic [1:0] REQ;
    logic       ACK = 1'b0;
    logic [3:0] GPIO_DI = 4'h0;
    logic       GPIO_ICL = 1'b0;
    logic       ovf;

    isa_pi_link #(
        .PORT_BASE (BASE),
        .NCH       (NCH),
        .OUT_AW    (OUT_AW),
        .IN_AW     (IN_AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .D_i      (D_i),
        .D_o      (D_o),
        .D_oe     (D_oe),
        .IOR      (IOR),
        .IOW      (IOW),
        .GPIO_AD  (GPIO_AD),
        .REQ      (REQ),
        .ACK      (ACK),
        .GPIO_DI  (GPIO_DI),
        .GPIO_ICL (GPIO_ICL),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Model: output queue holds {is_data, byte}; input queue holds nibbles.
    logic [8:0] out_q[$];
    logic [3:0] in_q[$];
    bit         m_out_ovf, m_in_ovf;

    function automatic logic [7:0] m_status();
        return {4'h0, m_in_ovf, m_out_ovf, (in_q.size() >= 2), (out_q.size() == 0)};
    endfunction

    task automatic m_reset();
        out_q.delete();
        in_q.delete();
        m_out_ovf = 1'b0;
        m_in_ovf  = 1'b0;
    endtask

    task automatic m_write(input logic [9:0] a, input logic [7:0] d);
        int ch;
        ch = int'(a) - int'(BASE);
        if (ch >= 0 && ch < NCH) begin
            if (OUT_DEPTH - out_q.size() >= 2) begin
                out_q.push_back({1'b0, 8'(ch)});
                out_q.push_back({1'b1, d});
            end else begin
                m_out_ovf = 1'b1;
            end
        end else if (a == STAT_PORT) begin
            if (d[0]) in_q.delete();
            if (d[1]) begin
                m_out_ovf = 1'b0;
                m_in_ovf  = 1'b0;
            end
        end
    endtask

    task automatic m_icl(input logic [3:0] n);
        if (in_q.size() < IN_DEPTH) in_q.push_back(n);
        else m_in_ovf = 1'b1;
    endtask

    task automatic m_read(input logic [9:0] a, output logic [7:0] v);
        if (a == STAT_PORT) begin
            v = m_status();
        end else if (in_q.size() >= 2) begin
            v = {in_q[1], in_q[0]};
            void'(in_q.pop_front());
            void'(in_q.pop_front());
        end else begin
            v = 8'hFF;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic isa_write(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        A = a; D_i = d; IOW = 1'b0;
        cyc(3);
        IOW = 1'b1;
        cyc(5);
        A = IDLE_A;
        m_write(a, d);
    endtask

    task automatic isa_read(input logic [9:0] a, output logic [7:0] d, output logic oe_mid,
                            output logic oe_end);
        @(negedge clk);
        A = a; IOR = 1'b0;
        cyc(5);
        d = D_o; oe_mid = D_oe;
        IOR = 1'b1;
        cyc(5);
        oe_end = D_oe;
        A = IDLE_A;
    endtask

    task automatic icl_pulse(input logic [3:0] n);
        @(negedge clk);
        GPIO_DI = n; GPIO_ICL = 1'b1;
        cyc(4);
        GPIO_ICL = 1'b0;
        cyc(4);
        m_icl(n);
    endtask

    task automatic pi_take(output logic [7:0] b, output logic [1:0] r, output bit ok);
        ok = 1'b0; b = '0; r = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (REQ[0]) ok = 1'b1;
        end
        if (ok) begin
            b = GPIO_AD; r = REQ;
            ACK = 1'b1;
            cyc(5);
            ACK = 1'b0;
            cyc(3);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       om, oe;
        do_reset();
        @(negedge clk);
        checks++; if (REQ !== 2'b00) $display("FAIL reset_req: got %b want 00", REQ); else passed++;
        checks++; if (GPIO_AD !== 8'h00) $display("FAIL reset_ad: got %h want 00", GPIO_AD); else passed++;
        checks++; if (D_o !== 8'h00) $display("FAIL reset_do: got %h want 00", D_o); else passed++;
        checks++; if (D_oe !== 1'b0) $display("FAIL reset_doe: got %b want 0", D_oe); else passed++;
        checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else passed++;
        cyc(4);
        isa_read(STAT_PORT, d, om, oe);
        checks++; if (d !== 8'h01) $display("FAIL reset_status: got %h want 01", d); else passed++;
        checks++; if (om !== 1'b1 || oe !== 1'b0)
            $display("FAIL reset_status_oe: got %b%b want 10", om, oe); else passed++;
    endtask

    task automatic test_single_write();
        logic [7:0] b;
        logic [1:0] r;
        bit         ok;
        isa_write(10'h171, 8'h5A);
        pi_take(b, r, ok);
        checks++; if (!ok || b !== 8'h01 || r !== 2'b01)
            $display("FAIL write_tag: got ok=%0d %h/%b want 01/01", ok, b, r); else passed++;
        void'(out_q.pop_front());
        pi_take(b, r, ok);
        checks++; if (!ok || b !== 8'h5A || r !== 2'b11)
            $display("FAIL write_data: got ok=%0d %h/%b want 5a/11", ok, b, r); else passed++;
        void'(out_q.pop_front());
        cyc(2);
        checks++; if (REQ !== 2'b00 || GPIO_AD !== 8'h5A)
            $display("FAIL write_idle: got %b/%h want 00/5a", REQ, GPIO_AD); else passed++;
    endtask

    task automatic test_out_overflow();
        logic [7:0] d, want, b;
        logic [1:0] r;
        logic       om, oe;
        bit         ok;
        for (int i = 0; i < 5; i++) isa_write(BASE + 10'(i % NCH), 8'($urandom));
        checks++; if (out_q.size() != 8 || !m_out_ovf)
            $display("FAIL ovf_model: got %0d want 8", out_q.size()); else passed++;
        isa_read(STAT_PORT, d, om, oe);
        checks++; if (d !== 8'h04) $display("FAIL ovf_status: got %h want 04", d); else passed++;
        checks++; if (ovf !== 1'b1) $display("FAIL ovf_pin: got %b want 1", ovf); else passed++;
        isa_write(STAT_PORT, 8'h02);
        isa_read(STAT_PORT, d, om, oe);
        m_read(STAT_PORT, want);
        checks++; if (d !== want || d[2] !== 1'b0)
            $display("FAIL ovf_clear: got %h want %h", d, want); else passed++;
        while (out_q.size() > 0) begin
            pi_take(b, r, ok);
            checks++; if (!ok || {r[1], b} !== out_q[0] || r[0] !== 1'b1)
                $display("FAIL ovf_drain: got ok=%0d %b/%h want %h", ok, r, b, out_q[0]); else passed++;
            void'(out_q.pop_front());
        end
    endtask

    task automatic test_in_fifo();
        logic [7:0] d;
        logic       om, oe;
        icl_pulse(4'h3);
        icl_pulse(4'hC);
        isa_read(DATA_PORT, d, om, oe);
        void'(in_q.pop_front()); void'(in_q.pop_front());
        checks++; if (d !== 8'hC3 || om !== 1'b1 || oe !== 1'b0)
            $display("FAIL in_data: got %h oe=%b%b want c3 10", d, om, oe); else passed++;
        isa_read(DATA_PORT, d, om, oe);
        checks++; if (d !== 8'hFF) $display("FAIL in_empty_read: got %h want ff", d); else passed++;
        isa_read(STAT_PORT, d, om, oe);
        checks++; if (d[1] !== 1'b0 || d !== m_status())
            $display("FAIL in_status: got %h want %h", d, m_status()); else passed++;
    endtask

    task automatic test_same_cycle();
        logic [7:0] d, b;
        logic [1:0] r;
        logic       om, oe;
        bit         ok;
        for (int i = 0; i < 3; i++) isa_write(BASE + 10'(i), 8'h10 + 8'(i));
        @(negedge clk);
        A = BASE + 10'd3; D_i = 8'hA7; IOW = 1'b0;
        cyc(3);
        IOW = 1'b1; ACK = 1'b1;
        cyc(5);
        ACK = 1'b0;
        cyc(3);
        A = IDLE_A;
        m_write(BASE + 10'd3, 8'hA7);
        void'(out_q.pop_front());
        isa_read(STAT_PORT, d, om, oe);
        checks++; if (d !== 8'h00 || ovf !== 1'b0)
            $display("FAIL same_cycle_status: got %h ovf=%b want 00/0", d, ovf); else passed++;
        isa_write(BASE, 8'h99);
        checks++; if (ovf !== 1'b1 || !m_out_ovf)
            $display("FAIL same_cycle_full: got ovf=%b want 1", ovf); else passed++;
        isa_write(STAT_PORT, 8'h02);
        while (out_q.size() > 0) begin
            pi_take(b, r, ok);
            checks++; if (!ok || {r[1], b} !== out_q[0])
                $display("FAIL same_cycle_drain: got ok=%0d %b/%h want %h", ok, r, b, out_q[0]); else passed++;
            void'(out_q.pop_front());
        end
    endtask

    task automatic test_unmapped();
        int seen;
        seen = 0;
        @(negedge clk);
        A = 10'h300; IOR = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (D_oe) seen++;
        end
        IOR = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (D_oe) seen++;
        end
        A = IDLE_A;
        checks++; if (seen != 0) $display("FAIL unmapped_oe: got %0d cycles high want 0", seen); else passed++;
    endtask

    task automatic test_reset_mid_drain();
        logic [7:0] d, b;
        logic [1:0] r;
        logic       om, oe;
        bit         ok;
        icl_pulse(4'h1);
        icl_pulse(4'h2);
        isa_write(10'h172, 8'h3C);
        pi_take(b, r, ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (REQ == 2'b11) ok = 1'b1;
        end
        checks++; if (!ok) $display("FAIL mid_drain_req: got %b want 11", REQ); else passed++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        checks++; if (REQ !== 2'b00 || D_oe !== 1'b0)
            $display("FAIL mid_reset_out: got %b/%b want 00/0", REQ, D_oe); else passed++;
        cyc(4);
        isa_read(STAT_PORT, d, om, oe);
        checks++; if (d !== 8'h01) $display("FAIL mid_reset_status: got %h want 01", d); else passed++;
    endtask

    task automatic test_random();
        logic [7:0] d, want, b;
        logic [1:0] r;
        logic       om, oe;
        bit         ok;
        logic [9:0] a;
        for (int n = 0; n < 70; n++) begin
            case ($urandom_range(0, 6))
                0, 1: isa_write(BASE + 10'($urandom_range(0, NCH - 1)), 8'($urandom));
                2: isa_write(STAT_PORT, 8'($urandom_range(0, 3)));
                3: icl_pulse(4'($urandom));
                4: begin
                    a = $urandom_range(0, 1) ? DATA_PORT : STAT_PORT;
                    isa_read(a, d, om, oe);
                    m_read(a, want);
                    checks++; if (d !== want || om !== 1'b1 || oe !== 1'b0)
                        $display("FAIL rand_read %h: got %h oe=%b%b want %h", a, d, om, oe, want); else passed++;
                end
                default: if (out_q.size() > 0) begin
                    pi_take(b, r, ok);
                    checks++; if (!ok || {r[1], b} !== out_q[0] || r[0] !== 1'b1)
                        $display("FAIL rand_take: got ok=%0d %b/%h want %h", ok, r, b, out_q[0]); else passed++;
                    void'(out_q.pop_front());
                end
            endcase
        end
        checks++; if (ovf !== (m_out_ovf | m_in_ovf))
            $display("FAIL rand_ovf: got %b want %b", ovf, m_out_ovf | m_in_ovf); else passed++;
        while (out_q.size() > 0) begin
            pi_take(b, r, ok);
            checks++; if (!ok || {r[1], b} !== out_q[0])
                $display("FAIL rand_drain: got ok=%0d %b/%h want %h", ok, r, b, out_q[0]); else passed++;
            void'(out_q.pop_front());
        end
        isa_read(STAT_PORT, d, om, oe);
        checks++; if (d !== m_status()) $display("FAIL rand_final_status: got %h want %h", d, m_status()); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_out_overflow();
        test_in_fifo();
        test_same_cycle();
        test_unmapped();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/isa_pi_link.md
ISA_PI_LINK -- requirements
Module: isa_pi_link

Interface
REQ-001 Parameter PORT_BASE, 10'h170, first ISA I/O port of the block window.
REQ-002 Parameter NCH, 4, number of write channels (1..15); ports PORT_BASE..PORT_BASE+NCH-1.
REQ-003 Parameter OUT_AW, 8, log2 of output FIFO depth in bytes.
REQ-004 Parameter IN_AW, 10, log2 of input FIFO depth in nibbles.
REQ-005 clk  in  1  system clock; sole clock, all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 A  in  10  ISA address; D_i  in  8  ISA data in; D_o  out  8  ISA data out; D_oe  out  1  D_o drive enable.
REQ-008 IOR, IOW  in  1 each  ISA strobes, active-low, asynchronous.
REQ-009 GPIO_AD  out  8  byte to Pi; REQ  out  2  [0]=valid, [1]=phase (0 tag, 1 data); ACK  in  1  Pi acknowledge, asynchronous.
REQ-010 GPIO_DI  in  4  nibble from Pi; GPIO_ICL  in  1  nibble strobe, asynchronous.
REQ-011 ovf  out  1  sticky overflow indicator (either FIFO).

Function
REQ-012 IOW, IOR, ACK and GPIO_ICL SHALL each pass a 2-flop synchroniser; edges are detected on the synchronised value (IOW rising, IOR falling, IOR rising, ACK rising, ICL rising).
REQ-013 On IOW rising with A = PORT_BASE+i (i<NCH), the block SHALL push tag byte i then byte D_i into the output FIFO in the same cycle.
REQ-014 If fewer than 2 output entries are free, both bytes SHALL be dropped and out_ovf set; pairs are never split.
REQ-015 Output drain: while FIFO non-empty, REQ[0]=1, REQ[1]=read-pointer bit 0, GPIO_AD=head byte; on ACK rising the pointer SHALL advance by one; when empty, REQ=0 and GPIO_AD holds its last value.
REQ-016 Push and pop in the same cycle SHALL both take effect; the count is updated by +2-1.
REQ-017 On GPIO_ICL rising the GPIO_DI nibble SHALL be pushed into the input FIFO; if full, it is dropped and in_ovf set.
REQ-018 Status port PORT_BASE+NCH read value = {4'b0, in_ovf, out_ovf, in_cnt>=2, out_empty}; ovf = out_ovf | in_ovf.
REQ-019 Data port PORT_BASE+NCH+1 read with in_cnt>=2 SHALL return {second nibble, first nibble} and pop 2; with in_cnt<2 it SHALL return 8'hFF and pop nothing.
REQ-020 Write to the status port: D_i[0]=1 flushes the input FIFO, D_i[1]=1 clears both overflow flags; nothing is pushed to the output FIFO.
REQ-021 On IOR falling with A in the read ports, D_o SHALL be loaded and D_oe set the next cycle; on IOR rising D_oe SHALL clear; other addresses leave D_oe=0.
REQ-022 Pointers SHALL wrap modulo depth; full/empty are taken from an (AW+1)-bit occupancy count.
REQ-023 An ICL push and a data-port pop in the same cycle SHALL both take effect.

Reset
REQ-024 When rst_n=0 at a clk edge: FIFOs empty, flags 0, REQ=0, GPIO_AD=0, D_o=0, D_oe=0, synchronisers 0; this takes precedence over every event, including mid-handshake.
REQ-025 A handshake byte in flight at reset SHALL be discarded; the Pi resynchronises on REQ[1]=0.

Structure
REQ-026 Package isa_pi_pkg SHALL hold status-bit positions, the read-port offsets (NCH, NCH+1) and the empty-read value 8'hFF.
REQ-027 One sub-module, sync_fifo (parameters WIDTH, AW; dual-push option), SHALL be instantiated for the output (8-bit) and input (4-bit) FIFOs.

Verification
REQ-028 IOW to 0x171 with D=0x5A, Pi ACKs each byte -> GPIO_AD 0x01 with REQ=2'b01, then 0x5A with REQ=2'b11, then REQ=0.
REQ-029 OUT_AW=3, 5 writes with no ACK -> first 4 pairs queued, fifth dropped, status bit2=1; write 0x02 to status -> bit2=0.
REQ-030 ICL nibbles 0x3,0xC then read 0x175 -> D_o=0xC3; immediate second read -> 0xFF, status bit1=0.
REQ-031 ACK rising in the same cycle as an IOW push at count 6 (OUT_AW=3) -> count 7, no overflow.
REQ-032 rst_n low for one cycle mid-drain with REQ=2'b11 -> next cycle REQ=0, D_oe=0, status=0x01.
REQ-033 IOR pulse at unmapped port 0x300 -> D_oe stays 0 throughout.
